// File: rtl/stat_counter_bank.sv
// Bank of N saturating event counters with a live display tap and a
// byte-serial snapshot dump (A5 header, then each counter MSB byte first).
module stat_counter_bank #(
  parameter int N = 4,
  parameter int W = 16,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic [N-1:0]  inc_i,
  input  logic          clr_i,
  input  logic [SW-1:0] sel_i,
  output logic [W-1:0]  disp_o,
  output logic [N-1:0]  sat_o,
  input  logic          dump_req_i,
  output logic          dump_busy_o,
  output logic          out_vld_o,
  input  logic          out_rdy_i,
  output logic [7:0]    out_data_o,
  output logic          out_last_o
);

  localparam int NB    = W / 8;
  localparam int L     = 1 + N * NB;
  localparam int IW    = $clog2(L + 1);
  localparam int SNAPW = N * W;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      count_q [N];
  logic [W-1:0]      count_d [N];
  logic [N-1:0]      sat_q, sat_d;
  logic [W-1:0]      disp_q, disp_d;
  logic [SNAPW-1:0]  snap_q, snap_d;
  logic [SNAPW-1:0]  snapIn;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic              last_q, last_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;

  // clr dominates inc; an increment at all-ones holds the count and flags saturation.
  always_comb begin
    sat_d = sat_q;
    for (int i = 0; i < N; i++) begin
      count_d[i] = count_q[i];
      if (clr_i) begin
        count_d[i] = '0;
        sat_d[i]   = 1'b0;
      end else if (inc_i[i]) begin
        if (&count_q[i]) begin
          sat_d[i] = 1'b1;
        end else begin
          count_d[i] = count_q[i] + W'(1);
        end
      end
    end
  end

  always_comb begin
    disp_d = '0;
    if (int'(sel_i) < N) begin
      disp_d = count_q[sel_i];
    end
  end

  // Channel 0 sits in the top bits so the dump simply shifts the snapshot left.
  always_comb begin
    snapIn = '0;
    for (int i = 0; i < N; i++) begin
      snapIn[(N-1-i)*W +: W] = count_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    data_d  = data_q;
    last_d  = last_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (dump_req_i) begin
          state_d = SEND;
          snap_d  = snapIn;
          idx_d   = '0;
          data_d  = 8'hA5;
          last_d  = 1'b0;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (vld_q && out_rdy_i) begin
          if (idx_q == IW'(L - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
          end else begin
            idx_d  = idx_q + IW'(1);
            data_d = snap_q[SNAPW-1 -: 8];
            snap_d = snap_q << 8;
            last_d = (idx_q == IW'(L - 2));
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      for (int i = 0; i < N; i++) begin
        count_q[i] <= '0;
      end
      sat_q  <= '0;
      disp_q <= '0;
      snap_q <= '0;
      idx_q  <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < N; i++) begin
        count_q[i] <= count_d[i];
      end
      sat_q  <= sat_d;
      disp_q <= disp_d;
      snap_q <= snap_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      last_q <= last_d;
      vld_q  <= vld_d;
      busy_q <= busy_d;
    end
  end

  assign disp_o      = disp_q;
  assign sat_o       = sat_q;
  assign dump_busy_o = busy_q;
  assign out_vld_o   = vld_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

endmodule

// File: tb/tb_stat_counter_bank.sv
// Self-checking bench for stat_counter_bank: behavioural counter/dump model
// feeding a byte scoreboard, a hand-written vector table, and corner sequences.
module tb_stat_counter_bank;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int NB = W / 8;
  localparam int L  = 1 + N * NB;

  logic         clk_i = 1'b0;
  logic         resetn_i;
  logic [N-1:0] inc_i;
  logic         clr_i;
  logic [1:0]   sel_i;
  logic [W-1:0] disp_o;
  logic [N-1:0] sat_o;
  logic         dump_req_i;
  logic         dump_busy_o;
  logic         out_vld_o;
  logic         out_rdy_i;
  logic [7:0]   out_data_o;
  logic         out_last_o;

  always #5 clk_i = ~clk_i;

  stat_counter_bank #(.N(N), .W(W)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .inc_i(inc_i), .clr_i(clr_i),
    .sel_i(sel_i), .disp_o(disp_o), .sat_o(sat_o), .dump_req_i(dump_req_i),
    .dump_busy_o(dump_busy_o), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o)
  );

  int errors = 0;
  int checks = 0;
  int bytesSeen = 0;
  logic [8:0] sbq[$];
  logic [W-1:0] mCnt [N];
  logic [N-1:0] mSat;
  bit mBusy;
  int mRem;

  typedef struct {
    logic [N-1:0] inc;
    logic         clr;
    logic [1:0]   sel;
    logic [W-1:0] expDisp;
    logic [N-1:0] expSat;
  } vec_t;
  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then compare after the edge.
  task automatic applyStimulus(input logic [N-1:0] inc, input logic clr, input logic [1:0] sel,
                               input logic req, input logic rdy);
    logic [W-1:0] expDisp;
    bit wasBusy;
    inc_i = inc; clr_i = clr; sel_i = sel; dump_req_i = req; out_rdy_i = rdy;
    @(posedge clk_i);
    expDisp = mCnt[sel];
    wasBusy = mBusy;
    if (wasBusy) begin
      if (rdy) begin
        mRem--;
        if (mRem == 0) mBusy = 0;
      end
    end else if (req) begin
      sbq.push_back({1'b0, 8'hA5});
      for (int i = 0; i < N; i++)
        for (int b = 0; b < NB; b++)
          sbq.push_back({(i == N-1 && b == NB-1), mCnt[i][W-1-8*b -: 8]});
      mBusy = 1;
      mRem  = L;
    end
    for (int i = 0; i < N; i++) begin
      if (clr) begin
        mCnt[i] = '0;
        mSat[i] = 1'b0;
      end else if (inc[i]) begin
        if (mCnt[i] == {W{1'b1}}) mSat[i] = 1'b1;
        else mCnt[i] = mCnt[i] + 1'b1;
      end
    end
    #1;
    checkOutput("disp", 32'(disp_o), 32'(expDisp));
    checkOutput("sat", 32'(sat_o), 32'(mSat));
    checkOutput("dump_busy", 32'(dump_busy_o), 32'(mBusy));
    checkOutput("out_vld", 32'(out_vld_o), 32'(mBusy));
  endtask

  task automatic doReset();
    resetn_i = 1'b0; inc_i = '0; clr_i = 1'b0; sel_i = '0; dump_req_i = 1'b0; out_rdy_i = 1'b1;
    @(posedge clk_i);
    for (int i = 0; i < N; i++) mCnt[i] = '0;
    mSat = '0; mBusy = 0; mRem = 0;
    sbq.delete();
    #1;
    resetn_i = 1'b1;
    checkOutput("reset disp", 32'(disp_o), 32'h0);
    checkOutput("reset sat", 32'(sat_o), 32'h0);
    checkOutput("reset busy", 32'(dump_busy_o), 32'h0);
    checkOutput("reset vld", 32'(out_vld_o), 32'h0);
    checkOutput("reset last", 32'(out_last_o), 32'h0);
    checkOutput("reset data", 32'(out_data_o), 32'h0);
  endtask

  task automatic runDump(input string tag, input bit randRdy, input bit randInc, output int cycles);
    bytesSeen = 0;
    cycles = 0;
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b1);
    while (mBusy && cycles < 400) begin
      applyStimulus(randInc ? N'($urandom) : '0, 1'b0, 2'($urandom), 1'b0,
                    randRdy ? 1'($urandom_range(0, 1)) : 1'b1);
      cycles++;
    end
    checkOutput({tag, " done"}, 32'(dump_busy_o), 32'h0);
    checkOutput({tag, " bytes"}, 32'(bytesSeen), 32'(L));
    checkOutput({tag, " queue empty"}, 32'(sbq.size()), 32'h0);
  endtask

  // Scoreboard monitor: pops on each handshake and checks stall stability.
  logic       prevStall = 1'b0;
  logic [7:0] prevData;
  logic       prevLast;
  always @(negedge clk_i) begin
    if (!resetn_i) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall data", 32'(out_data_o), 32'(prevData));
        checkOutput("stall last", 32'(out_last_o), 32'(prevLast));
      end
      if (out_vld_o && out_rdy_i) begin
        bytesSeen++;
        if (sbq.size() == 0) begin
          checkOutput("extra byte", 32'(out_data_o), 32'hFFFF_FFFF);
        end else begin
          logic [8:0] e;
          e = sbq.pop_front();
          checkOutput("out_data", 32'(out_data_o), 32'(e[7:0]));
          checkOutput("out_last", 32'(out_last_o), 32'(e[8]));
        end
      end
      prevStall = out_vld_o && !out_rdy_i;
      prevData  = out_data_o;
      prevLast  = out_last_o;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    vecs[0] = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0};
    vecs[1] = '{4'b0011, 1'b0, 2'd0, 16'd1, 4'b0};
    vecs[2] = '{4'b0010, 1'b0, 2'd1, 16'd1, 4'b0};
    vecs[3] = '{4'b0000, 1'b0, 2'd1, 16'd2, 4'b0};
    vecs[4] = '{4'b1111, 1'b0, 2'd3, 16'd0, 4'b0};
    vecs[5] = '{4'b0000, 1'b0, 2'd2, 16'd1, 4'b0};
    vecs[6] = '{4'b0100, 1'b1, 2'd0, 16'd3, 4'b0};
    vecs[7] = '{4'b0000, 1'b0, 2'd0, 16'd0, 4'b0};
    vecs[8] = '{4'b0001, 1'b0, 2'd0, 16'd0, 4'b0};
    vecs[9] = '{4'b0000, 1'b0, 2'd0, 16'd1, 4'b0};

    for (int i = 0; i < N; i++) mCnt[i] = '0;
    mSat = '0; mBusy = 0; mRem = 0;
    doReset();

    $display("[TB] vector table");
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].inc, vecs[v].clr, vecs[v].sel, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d disp", v), 32'(disp_o), 32'(vecs[v].expDisp));
      checkOutput($sformatf("vec%0d sat", v), 32'(sat_o), 32'(vecs[v].expSat));
    end

    $display("[TB] reset after random activity");
    for (int c = 0; c < 40; c++)
      applyStimulus(N'($urandom), 1'($urandom_range(0, 9) == 0), 2'($urandom),
                    1'($urandom_range(0, 3) == 0), 1'($urandom));
    doReset();
    runDump("t1 zero dump", 1'b0, 1'b0, cyc);

    $display("[TB] basic dump");
    doReset();
    for (int c = 0; c < 5; c++) applyStimulus({2'b00, 1'b1, (c < 3)}, 1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 2'd1, 1'b0, 1'b1);
    checkOutput("t2 disp1", 32'(disp_o), 32'd5);
    runDump("t2 dump", 1'b0, 1'b0, cyc);
    checkOutput("t2 latency", 32'(cyc), 32'(L));

    $display("[TB] saturation and clear");
    for (int c = 0; c < 65537; c++) applyStimulus(4'b0100, 1'b0, 2'd2, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 2'd2, 1'b0, 1'b1);
    checkOutput("t3 disp sat", 32'(disp_o), 32'hFFFF);
    checkOutput("t3 sat flags", 32'(sat_o), 32'h4);
    applyStimulus('0, 1'b1, 2'd2, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 2'd2, 1'b0, 1'b1);
    checkOutput("t3 disp cleared", 32'(disp_o), 32'h0);
    checkOutput("t3 sat cleared", 32'(sat_o), 32'h0);
    for (int c = 0; c < 3; c++) applyStimulus(4'b0100, 1'b0, 2'd2, 1'b0, 1'b1);
    applyStimulus(4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 2'd2, 1'b0, 1'b1);
    checkOutput("t3 clr beats inc", 32'(disp_o), 32'h0);

    $display("[TB] backpressure with live increments");
    for (int c = 0; c < 20; c++) applyStimulus(N'($urandom), 1'b0, 2'($urandom), 1'b0, 1'b1);
    runDump("t4 dump", 1'b1, 1'b1, cyc);

    $display("[TB] dump_req while busy");
    bytesSeen = 0;
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b1);
    cyc = 0;
    while (mBusy && cyc < 400) begin
      applyStimulus('0, 1'b0, '0, 1'(cyc % 2 == 0), 1'($urandom));
      cyc++;
    end
    checkOutput("t5 one dump bytes", 32'(bytesSeen), 32'(L));
    checkOutput("t5 queue empty", 32'(sbq.size()), 32'h0);
    runDump("t5 second dump", 1'b0, 1'b0, cyc);

    $display("[TB] reset mid-dump");
    for (int c = 0; c < 4; c++) applyStimulus(4'b1011, 1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, '0, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) applyStimulus('0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("t6 remaining", 32'(sbq.size()), 32'(L - 4));
    doReset();
    for (int c = 0; c < 6; c++) applyStimulus('0, 1'b0, 2'(c), 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stat_counter_bank.md
Name: stat_counter_bank

Overview:
Parametrised bank of N saturating event counters for MAC/ARP/UART statistics. It generalises the fixed per-event counter logic next to the seg7 display. Each channel counts single-cycle increment pulses. One selected channel is presented live for display. On request, all counters are snapshotted and streamed out as a byte sequence over a valid/ready handshake; the stream feeds bin2char/minififo for UART dumping.

Parameters:
N, 4, number of counter channels (>=2)
W, 16, counter width in bits; multiple of 8, 8..32
SW, $clog2(N), select width (derived, not overridden)

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
inc  input  N  per-channel increment pulse, one count per cycle high
clr  input  1  clear all counters and saturation flags
sel  input  SW  channel shown on disp
disp  output  W  registered value of counter[sel]
sat  output  N  sticky per-channel saturation flag
dump_req  input  1  pulse: snapshot all counters and start dump
dump_busy  output  1  dump in progress
out_vld  output  1  out_data valid
out_rdy  input  1  downstream accepts byte
out_data  output  8  dump byte
out_last  output  1  marks final byte of dump

Behaviour:
- Reset (resetn=0 at posedge) applies to all counters, sat, disp, dump_busy, out_vld, out_last and out_data; all become 0. The state machine returns to IDLE. Reset mid-dump aborts the dump; no further bytes are sent.
- Counter update per channel i, priority order:
  - clr=1: counter <= 0, sat[i] <= 0. clr beats a simultaneous inc[i].
  - else inc[i]=1 and counter != all-ones: counter <= counter+1.
  - else inc[i]=1 and counter == all-ones: counter holds, sat[i] <= 1.
- Counters never wrap. sat[i] stays set until clr or reset.
- disp <= counter[sel] each cycle; 1-cycle latency from counter/sel change. sel >= N gives disp <= 0.
- State machine IDLE -> SEND -> IDLE:
  - IDLE: dump_req=1 copies all N counters (register values at that edge, pre-increment) into a snapshot and sets byte index 0. Next cycle: dump_busy=1, out_vld=1, SEND.
  - dump_req in SEND is ignored; no restart, no queuing.
  - SEND: byte sequence is index 0 = 8'hA5 header, then channel 0..N-1, each counter MSB byte first. Total L = 1 + N*W/8 bytes.
  - Transfer occurs on a cycle with out_vld & out_rdy; the index advances and the next byte appears the following cycle.
  - With out_rdy held high, the stream is one byte per cycle, no bubbles.
  - While out_vld & ~out_rdy, out_data and out_last hold stable.
  - out_last=1 only with byte L-1.
  - The transfer of the last byte returns to IDLE. Next cycle: out_vld=0, dump_busy=0, out_last=0.
  - A new dump_req is accepted the cycle after dump_busy falls.
- Snapshot isolation: inc and clr during SEND update the live counters, sat and disp, never the dumped bytes.
- Latency: dump_req at edge t -> header valid after t. With out_rdy=1 throughout, last byte transfers at edge t+L.
- Widths: all counter arithmetic at W bits. Byte index width is $clog2(L+1).

Test Plan:
1. Reset with N=4, W=16 after random activity -> disp=0, sat=0, out_vld=0, dump_busy=0; dump gives A5 followed by eight 00 bytes.
2. 3 pulses on inc[0], 5 on inc[1], out_rdy=1, dump_req -> exactly 9 bytes A5,00,03,00,05,00,00,00,00 on consecutive cycles; out_last only on byte 9; dump_busy low the cycle after.
3. 65537 pulses on inc[2] -> counter[2]=FFFF, sat=4'b0100, disp with sel=2 reads FFFF. Then clr -> counter 0, sat 0. clr and inc[2] in the same cycle -> 0.
4. Random out_rdy backpressure during a dump -> out_data/out_last stable whenever stalled. inc pulses on all channels mid-dump change disp but not dumped bytes; byte count still 9.
5. dump_req pulsed repeatedly while dump_busy=1 -> exactly one dump of 9 bytes. dump_req the cycle after busy falls -> a second dump starts.
6. resetn low on byte 4 of a dump -> out_vld=0 next cycle, no further bytes, counters and sat 0.
